// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer: initial AddRoundKey on accept, then NR datapath steps.
// Optional completed-block counter (blk_count) when AES_SCHED_PERF_CNT_EN is defined.
module aes_round_sched #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         key_ready,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_decrypt,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_key,
   output logic [127:0] dp_state,
   output logic         dp_decrypt,
   output logic         dp_last,
   input  logic [127:0] dp_next
`ifdef AES_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]  blk_count
`endif
);

   localparam logic [3:0] NR_L = 4'(NR);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} st_e;

   st_e          st_q, st_d;
   logic [127:0] state_q, state_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         dec_q, dec_d;
   logic         accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= IDLE;
         state_q <= '0;
         rnd_q   <= '0;
         dec_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         state_q <= state_d;
         rnd_q   <= rnd_d;
         dec_q   <= dec_d;
      end
   end

   always_comb begin
      st_d      = st_q;
      state_d   = state_q;
      rnd_d     = rnd_q;
      dec_d     = dec_q;
      dp_last   = 1'b0;
      out_valid = (st_q == DONE);
      // DONE also accepts when the result leaves in the same cycle: no input bubble
      in_ready  = ((st_q == IDLE) | ((st_q == DONE) & out_ready)) & key_ready & ~flush;
      accept    = in_valid & in_ready;
      rk_idx    = in_decrypt ? NR_L : 4'd0;

      case (st_q)
         IDLE: begin
            if (accept) begin
               state_d = in_data ^ rk_key;
               dec_d   = in_decrypt;
               rnd_d   = 4'd1;
               st_d    = ROUND;
            end
         end
         ROUND: begin
            rk_idx  = dec_q ? (NR_L - rnd_q) : rnd_q;
            dp_last = (rnd_q == NR_L);
            state_d = dp_next;
            if (rnd_q == NR_L) st_d = DONE;
            else               rnd_d = rnd_q + 4'd1;
         end
         DONE: begin
            if (out_ready) begin
               if (accept) begin
                  state_d = in_data ^ rk_key;
                  dec_d   = in_decrypt;
                  rnd_d   = 4'd1;
                  st_d    = ROUND;
               end else begin
                  st_d = IDLE;
               end
            end
         end
         default: st_d = IDLE;
      endcase

      // abort wins over everything; the state register keeps its last value
      if (flush) begin
         st_d    = IDLE;
         rnd_d   = 4'd0;
         state_d = state_q;
         dec_d   = dec_q;
      end
   end

   assign out_data   = state_q;
   assign dp_state   = state_q;
   assign dp_decrypt = dec_q;

`ifdef AES_SCHED_PERF_CNT_EN
   logic [31:0] blk_count_q, blk_count_d;

   assign blk_count_d = (out_valid & out_ready) ? blk_count_q + 32'd1 : blk_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blk_count_q <= '0;
      else        blk_count_q <= blk_count_d;
   end

   assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: plays the round datapath and key store with a behavioural AES model.
module tb_aes_round_sched;

   localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         rst_n, flush, key_ready, in_valid, in_decrypt, out_ready;
   logic         in_ready, out_valid, dp_decrypt, dp_last;
   logic [127:0] in_data, out_data, rk_key, dp_state, dp_next;
   logic [3:0]   rk_idx;
`ifdef AES_SCHED_PERF_CNT_EN
   logic [31:0]  blk_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int tbl_ver  = 0;

   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk    [11];
   logic [3:0]   seq_idx  [16];
   logic         seq_last [16];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_round_sched #(.NR(10)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .key_ready(key_ready),
      .in_valid(in_valid), .in_ready(in_ready), .in_decrypt(in_decrypt), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rk_idx(rk_idx), .rk_key(rk_key), .dp_state(dp_state), .dp_decrypt(dp_decrypt),
      .dp_last(dp_last), .dp_next(dp_next)
`ifdef AES_SCHED_PERF_CNT_EN
      , .blk_count(blk_count)
`endif
   );

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(logic [7:0] x, int n);
      return 8'((x << n) | (x >> (8 - n)));
   endfunction

   // SubBytes and ShiftRows together (they commute); byte (row r, col c) sits at 4c+r
   function automatic logic [127:0] sub_shift(logic [127:0] s, bit inv);
      logic [127:0] o;
      logic [7:0]   b;
      int           sc;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
            b  = s[127 - 8*(4*sc + r) -: 8];
            o[127 - 8*(4*c + r) -: 8] = inv ? isbox[b] : sbox[b];
         end
      return o;
   endfunction

   function automatic logic [127:0] mix(logic [127:0] s, bit inv);
      logic [127:0] o;
      logic [7:0]   m [4];
      logic [7:0]   a [4];
      logic [7:0]   b;
      o = '0;
      if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
      else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
         for (int r = 0; r < 4; r++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b ^= gmul(m[(j - r + 4) % 4], a[j]);
            o[127 - 8*(4*c + r) -: 8] = b;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] enc_round(logic [127:0] s, logic [127:0] k, bit last);
      logic [127:0] t;
      t = sub_shift(s, 1'b0);
      if (!last) t = mix(t, 1'b0);
      return t ^ k;
   endfunction

   function automatic logic [127:0] dec_round(logic [127:0] s, logic [127:0] k, bit last);
      logic [127:0] t;
      t = sub_shift(s, 1'b1) ^ k;
      if (!last) t = mix(t, 1'b1);
      return t;
   endfunction

   function automatic logic [127:0] ref_cipher(logic [127:0] blk, logic dec);
      logic [127:0] s;
      s = blk ^ rk[dec ? 10 : 0];
      for (int r = 1; r <= 10; r++)
         s = dec ? dec_round(s, rk[10 - r], r == 10) : enc_round(s, rk[r], r == 10);
      return s;
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         for (int j = 1; j < 256; j++) if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[i]  = s;
         isbox[s] = 8'(i);
      end
   endtask

   task automatic expand_key(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      tbl_ver++;
   endtask

   // external key store and round datapath, both combinational
   always @(rk_idx or tbl_ver) rk_key = (rk_idx <= 4'd10) ? rk[rk_idx] : '0;
   always @(dp_state or rk_key or dp_decrypt or dp_last or tbl_ver)
      dp_next = dp_decrypt ? dec_round(dp_state, rk_key, dp_last)
                           : enc_round(dp_state, rk_key, dp_last);

   // drives one block with out_ready high; records rk_idx/dp_last per cycle and latency
   task automatic do_block(input logic [127:0] blk, input logic dec,
                           output logic [127:0] res, output int lat);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = blk; in_decrypt = dec; out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      seq_idx[0] = rk_idx; seq_last[0] = dp_last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat < 16) begin seq_idx[lat] = rk_idx; seq_last[lat] = dp_last; end
      end while (!out_valid && lat < 60);
      res = out_data;
      @(posedge clk); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; key_ready = 1'b1; in_valid = 1'b0;
      in_decrypt = 1'b0; in_data = '0; out_ready = 1'b0;
      #23;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      n_checks++; if (dp_state !== '0) begin n_fail++; $display("FAIL reset_dp_state got %h exp 0", dp_state); end
      n_checks++; if (dp_last !== 1'b0 || dp_decrypt !== 1'b0) begin n_fail++; $display("FAIL reset_dp_ctl got %b%b exp 00", dp_last, dp_decrypt); end
`ifdef AES_SCHED_PERF_CNT_EN
      n_checks++; if (blk_count !== 32'd0) begin n_fail++; $display("FAIL reset_blk_count got %0d exp 0", blk_count); end
`endif
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_checks++; if (rk_idx !== 4'd0) begin n_fail++; $display("FAIL reset_rk_idx_enc got %0d exp 0", rk_idx); end
      key_ready = 1'b0; in_decrypt = 1'b1; #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL key_ready_low_in_ready got %b exp 0", in_ready); end
      n_checks++; if (rk_idx !== 4'd10) begin n_fail++; $display("FAIL idle_rk_idx_dec got %0d exp 10", rk_idx); end
      key_ready = 1'b1; in_decrypt = 1'b0;
   endtask

   task automatic test_fips_enc();
      logic [127:0] res;
      int lat;
      do_block(PT, 1'b0, res, lat);
      n_checks++; if (res !== CT) begin n_fail++; $display("FAIL fips_enc_data got %h exp %h", res, CT); end
      n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL fips_enc_latency got %0d exp 11", lat); end
      for (int r = 0; r <= 10; r++) begin
         n_checks++; if (seq_idx[r] !== 4'(r)) begin n_fail++; $display("FAIL fips_enc_rk_idx[%0d] got %0d exp %0d", r, seq_idx[r], r); end
         n_checks++; if (seq_last[r] !== (r == 10)) begin n_fail++; $display("FAIL fips_enc_dp_last[%0d] got %b exp %b", r, seq_last[r], r == 10); end
      end
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fips_enc_out_valid_drop got %b exp 0", out_valid); end
   endtask

   task automatic test_fips_dec();
      logic [127:0] res;
      int lat;
      do_block(CT, 1'b1, res, lat);
      n_checks++; if (res !== PT) begin n_fail++; $display("FAIL fips_dec_data got %h exp %h", res, PT); end
      n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL fips_dec_latency got %0d exp 11", lat); end
      for (int r = 0; r <= 10; r++) begin
         n_checks++; if (seq_idx[r] !== 4'(10 - r)) begin n_fail++; $display("FAIL fips_dec_rk_idx[%0d] got %0d exp %0d", r, seq_idx[r], 10 - r); end
         n_checks++; if (seq_last[r] !== (r == 10)) begin n_fail++; $display("FAIL fips_dec_dp_last[%0d] got %b exp %b", r, seq_last[r], r == 10); end
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] b, exp_b;
      logic [127:0] out_dat [2];
      int acc_cyc [2];
      int out_cyc [2];
      int nacc, nout;
      logic acc;
      b = {$urandom, $urandom, $urandom, $urandom};
      exp_b = ref_cipher(b, 1'b1);
      nacc = 0; nout = 0;
      acc_cyc[0] = 0; acc_cyc[1] = 0; out_cyc[0] = 0; out_cyc[1] = 0;
      out_dat[0] = '0; out_dat[1] = '0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 60 && nout < 2; k++) begin
         @(negedge clk);
         acc = in_valid & in_ready;
         if (acc && nacc < 2) acc_cyc[nacc] = cyc;
         if (out_valid && out_ready) begin out_cyc[nout] = cyc; out_dat[nout] = out_data; nout++; end
         @(posedge clk); #1;
         if (acc) begin
            nacc++;
            if (nacc == 1) begin in_data = b; in_decrypt = 1'b1; end
            else in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      n_checks++; if (nacc !== 2) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 2", nacc); end
      n_checks++; if (nout !== 2) begin n_fail++; $display("FAIL b2b_outputs got %0d exp 2", nout); end
      n_checks++; if (out_dat[0] !== CT) begin n_fail++; $display("FAIL b2b_data0 got %h exp %h", out_dat[0], CT); end
      n_checks++; if (out_dat[1] !== exp_b) begin n_fail++; $display("FAIL b2b_data1 got %h exp %h", out_dat[1], exp_b); end
      n_checks++; if (acc_cyc[1] !== out_cyc[0]) begin n_fail++; $display("FAIL b2b_accept_in_done got cyc %0d exp %0d", acc_cyc[1], out_cyc[0]); end
      n_checks++; if (out_cyc[1] - out_cyc[0] !== 11) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 11", out_cyc[1] - out_cyc[0]); end
   endtask

   task automatic test_backpressure();
      logic [127:0] held;
      int n, deliv;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0; out_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      held = out_data;
      n_checks++; if (held !== CT) begin n_fail++; $display("FAIL bp_result got %h exp %h", held, CT); end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n_checks++; if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b %h exp v=1 %h", k, out_valid, out_data, held); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 0", k, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      deliv = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            deliv++;
            n_checks++; if (out_data !== CT) begin n_fail++; $display("FAIL bp_deliver_data got %h exp %h", out_data, CT); end
         end
      end
      n_checks++; if (deliv !== 1) begin n_fail++; $display("FAIL bp_deliveries got %0d exp 1", deliv); end
   endtask

   task automatic test_flush_reset();
      logic [127:0] res;
      int lat, n, seen;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0; out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 flush = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin @(negedge clk); if (out_valid) seen++; end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_output got %0d exp 0", seen); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready got %b exp 1", in_ready); end

      @(posedge clk); #1;
      in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_decrypt = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0; in_decrypt = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b exp 0", out_valid); end
      n_checks++; if (dp_state !== '0 || out_data !== '0) begin n_fail++; $display("FAIL rst_mid_state got %h exp 0", dp_state); end
      n_checks++; if (dp_decrypt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dp_decrypt got %b exp 0", dp_decrypt); end
      @(negedge clk); rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 20; k++) begin @(negedge clk); if (out_valid) seen++; end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_no_output got %0d exp 0", seen); end
      do_block(PT, 1'b0, res, lat);
      n_checks++; if (res !== CT) begin n_fail++; $display("FAIL post_rst_fips got %h exp %h", res, CT); end
      n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL post_rst_latency got %0d exp 11", lat); end
   endtask

   task automatic test_random();
      localparam int N = 40;
      logic [127:0] q [$];
      logic [127:0] exp_v, prev_data;
      logic accepted, hold_prev;
      int sent, got;
      expand_key({$urandom, $urandom, $urandom, $urandom});
      sent = 0; got = 0; hold_prev = 1'b0; prev_data = '0;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0; key_ready = 1'b1;
      for (int k = 0; k < 5000 && got < N; k++) begin
         @(negedge clk);
         if (!key_ready) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_keyready_block got %b exp 0", in_ready); end
         end
         if (hold_prev) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_fail++; $display("FAIL rnd_hold got v=%b %h exp v=1 %h", out_valid, out_data, prev_data); end
         end
         accepted = in_valid & in_ready;
         if (accepted) begin q.push_back(ref_cipher(in_data, in_decrypt)); sent++; end
         if (out_valid && out_ready) begin
            got++;
            exp_v = (q.size() > 0) ? q.pop_front() : 128'hx;
            n_checks++; if (out_data !== exp_v) begin n_fail++; $display("FAIL rnd_data[%0d] got %h exp %h", got, out_data, exp_v); end
         end
         hold_prev = out_valid & ~out_ready;
         prev_data = out_data;
         @(posedge clk); #1;
         if (!in_valid || accepted) begin
            in_valid   = (sent < N) && ($urandom_range(0, 3) != 0);
            in_data    = {$urandom, $urandom, $urandom, $urandom};
            in_decrypt = 1'($urandom_range(0, 1));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         key_ready = ($urandom_range(0, 7) != 0);
      end
      in_valid = 1'b0; out_ready = 1'b1; key_ready = 1'b1;
      n_checks++; if (got !== N) begin n_fail++; $display("FAIL rnd_count got %0d exp %0d", got, N); end
      n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL rnd_leftover got %0d exp 0", q.size()); end
      expand_key(KEY);
   endtask

`ifdef AES_SCHED_PERF_CNT_EN
   task automatic test_perf();
      logic [127:0] res;
      int lat, n;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) do_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), res, lat);
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = PT; in_decrypt = 1'b0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      repeat (15) @(negedge clk);
      n_checks++; if (blk_count !== 32'd3) begin n_fail++; $display("FAIL perf_count got %0d exp 3", blk_count); end
      @(posedge clk); #1;
      force dut.blk_count_q = 32'hFFFF_FFFF;
      #1 release dut.blk_count_q;
      do_block(PT, 1'b0, res, lat);
      n_checks++; if (blk_count !== 32'd0) begin n_fail++; $display("FAIL perf_wrap got %h exp 0", blk_count); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; key_ready = 1'b0; in_valid = 1'b0;
      in_decrypt = 1'b0; in_data = '0; out_ready = 1'b0;
      build_tables();
      expand_key(KEY);
      n_checks++; if (rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL model_key_sched got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", rk[10]); end
      test_reset();
      test_fips_enc();
      test_fips_dec();
      test_back_to_back();
      test_backpressure();
      test_flush_reset();
      test_random();
`ifdef AES_SCHED_PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_round_sched.md
# aes_round_sched

Iterative round sequencer for the AES cipher core. It accepts one 128-bit block through a valid/ready handshake and performs the initial AddRoundKey. It then steps an external combinational round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey, or their inverses) once per cycle for NR rounds, indexing the round-key store as it goes. It holds the result until the consumer takes it. It sits between the block-level stream interface and the round datapath plus key-expansion storage.

## Interface
- NR, 10, number of rounds (10/12/14 for AES-128/192/256); legal range 1..14
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort of any block in flight
- key_ready  in  1  round-key store holds a valid expanded key
- in_valid  in  1  input block valid
- in_ready  out  1  block accepted when in_valid & in_ready
- in_decrypt  in  1  1 = inverse cipher, sampled at accept
- in_data  in  128  input block, MSB-first byte order as the datapath
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  128  result (state register)
- rk_idx  out  4  round-key index, combinational
- rk_key  in  128  round key for rk_idx, same-cycle return
- dp_state  out  128  current state to datapath (= state register)
- dp_decrypt  out  1  selects inverse transforms
- dp_last  out  1  final round: datapath skips (Inv)MixColumns
- dp_next  in  128  datapath result for current round
- blk_count  out  32  completed-block counter (only with AES_SCHED_PERF_CNT_EN)

## Operation
- FSM states: IDLE, ROUND, DONE. Registers: state[127:0], rnd[3:0], dec.
- IDLE: in_ready = key_ready & ~flush. rk_idx = in_decrypt ? NR : 0. On accept: state <= in_data ^ rk_key, dec <= in_decrypt, rnd <= 1, go ROUND.
- ROUND: rk_idx = dec ? NR - rnd : rnd. dp_last = (rnd == NR). state <= dp_next. If rnd == NR go DONE, else rnd <= rnd + 1.
- DONE: out_valid = 1, out_data stable until handshake. On out_ready: if in_ready accept (same rules as IDLE), go ROUND; else go IDLE.
- in_ready = (IDLE | (DONE & out_ready)) & key_ready & ~flush. This allows back-to-back blocks with no bubble on the input side.
- dp_decrypt = dec. dp_last = 0 outside ROUND. rk_idx in DONE follows the IDLE rule.
- flush (any state): next state IDLE, out_valid drops next cycle, rnd <= 0; any pending result is discarded; no accept in the flush cycle.
- key_ready low only blocks new accepts; a block in flight completes with whatever rk_key returns.

## Timing
- Reset values: FSM IDLE; state, out_data, dp_state = 0; rnd = 0; dec = 0; out_valid = 0; dp_last = 0; dp_decrypt = 0; blk_count = 0. in_ready = key_ready after reset release.
- Accept at edge E0; rounds at edges E1..E_NR; out_valid high in the cycle after E_NR. Latency from accept to out_valid is NR+1 cycles.
- Throughput: one block per NR+1 cycles when out_ready is held high.
- The result handshake and a new accept may occur in the same DONE cycle; out_valid deasserts next cycle and the new block is in ROUND with rnd = 1.
- out_ready low in DONE: out_valid and out_data hold indefinitely; in_ready = 0.
- Reset asserted mid-block: all registers return to reset values immediately, with no partial output.

## Configuration
- AES_SCHED_PERF_CNT_EN defined: blk_count port exists. It increments by 1 on each out_valid & out_ready, wraps from 0xFFFFFFFF to 0, is not cleared by flush, and is cleared only by rst_n.
- Not defined: blk_count port and counter are absent; all other behaviour is identical.

## Test plan
- FIPS-197 App. B encrypt, NR=10: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734 -> out_valid exactly 11 cycles after accept, out_data 3925841d02dc09fbdc118597196a0b32; rk_idx sequence 0,1..10.
- Decrypt the same ciphertext with in_decrypt=1 -> out_data 3243f6a8885a308d313198a2e0370734; rk_idx sequence 10,9..0; dp_last high only on round 10.
- Two blocks back-to-back with out_ready=1 and in_valid held high -> second accept in the first block's DONE cycle, results 11 cycles apart, no lost or duplicated block.
- out_ready held low for 20 cycles in DONE -> out_data stable, in_ready=0, the held block is delivered once when out_ready rises.
- flush at round 5, then rst_n pulse at round 3 of the next block -> IDLE, out_valid=0, no output; a following encrypt yields the correct FIPS result.
- With AES_SCHED_PERF_CNT_EN: 3 completed blocks plus 1 flushed block -> blk_count = 3; preload via force to 0xFFFFFFFF, one completion -> 0.
